history_mem_ctrl: RTL and testbench

Owns the single-port per-pixel colour-history SRAM and serves the corner detector from both ends. It turns the incoming pixel stream into history reads and presents pixel, coordinates, address and 4-bit history to the detector. It accepts the detector's write-back of the updated history and schedules it into idle SRAM cycles through a small FIFO. It also wipes the memory after reset and on request.

---
 rtl/history_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 50 +++++
 rtl/history_mem_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_history_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/history_pkg.sv
// Shared types and default geometry for the colour-history memory controller.
package history_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned ADDR_W_DEF   = 19;
  localparam int unsigned HIST_W_DEF   = 4;
  localparam int unsigned WB_DEPTH_DEF = 4;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [HIST_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with full/empty flags and a synchronous flush.
// The head entry is presented combinationally on dout.
module wb_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/history_mem_ctrl.sv
// Colour-history SRAM controller: pixel-driven reads, FIFO-buffered write-back
// into idle slots, and a full-memory wipe after reset or on request.
module history_mem_ctrl
  import history_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned HIST_W   = HIST_W_DEF,
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [7:0]        pix_Cb,
  input  logic [7:0]        pix_Cr,
  input  logic              clear_req,
  output logic [7:0]        Cb,
  output logic [7:0]        Cr,
  output logic [9:0]        read_x,
  output logic [9:0]        read_y,
  output logic [ADDR_W-1:0] read_addr,
  output logic [HIST_W-1:0] color_history,
  output logic              color_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [HIST_W-1:0] updated_color_history,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [HIST_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic [HIST_W-1:0] sram_rdata,
  output logic              busy,
  output logic              overflow
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [HIST_W-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic [9:0]        x;
    logic [9:0]        y;
    logic [7:0]        cb;
    logic [7:0]        cr;
    logic [ADDR_W-1:0] addr;
    logic              hit;
  } tag_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_write;

  logic              pix_hit;
  logic [ADDR_W-1:0] pix_addr;
  logic              accept;
  logic              s1_valid;
  logic              s1_hit;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_valid;
  logic              rd_slot;

  tag_t              tag_in;
  tag_t              tag_out;
  logic              tag_push;
  logic              tag_pop;
  logic              tag_full;
  logic              tag_empty;

  wb_entry_t         wb_in;
  wb_entry_t         wb_head;
  logic              wb_push;
  logic              wb_pop;
  logic              wb_flush;
  logic              wb_full;
  logic              wb_empty;
  logic              wb_drop;

  always_comb begin
    pix_hit = (32'(pix_x) < H_ACTIVE) && (32'(pix_y) < V_ACTIVE);
    if (H_ACTIVE == 640)
      pix_addr = (ADDR_W'(pix_y) << 9) + (ADDR_W'(pix_y) << 7) + ADDR_W'(pix_x);
    else
      pix_addr = ADDR_W'(ADDR_W'(pix_y) * ADDR_W'(H_ACTIVE)) + ADDR_W'(pix_x);
  end

  assign accept = (state == RUN) && pix_valid && !tag_full;

  always_comb begin
    tag_in      = '0;
    tag_in.x    = pix_x;
    tag_in.y    = pix_y;
    tag_in.cb   = pix_Cb;
    tag_in.cr   = pix_Cr;
    tag_in.addr = pix_hit ? pix_addr : '0;
    tag_in.hit  = pix_hit;
  end

  // Pixel metadata rides a tiny FIFO from acceptance to the rdata cycle; it is
  // never flushed so reads in flight across a clear request still deliver.
  assign tag_push = accept;
  assign tag_pop  = s2_valid && !tag_empty;

  wb_fifo #(
    .W     ($bits(tag_t)),
    .DEPTH (2)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .push  (tag_push),
    .din   (tag_in),
    .pop   (tag_pop),
    .dout  (tag_out),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_hit   <= pix_hit;
      s1_addr  <= pix_addr;
      s2_valid <= s1_valid;
    end
  end

  assign rd_slot = s1_valid && s1_hit;

  assign wb_in.addr = write_addr;
  assign wb_in.data = updated_color_history;
  assign wb_flush   = (state == RUN) && clear_req;
  assign wb_push    = (state == RUN) && we && !clear_req;
  assign wb_drop    = wb_push && wb_full && !wb_pop;

  wb_fifo #(
    .W     ($bits(wb_entry_t)),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (wb_flush),
    .push  (wb_push),
    .din   (wb_in),
    .pop   (wb_pop),
    .dout  (wb_head),
    .full  (wb_full),
    .empty (wb_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_write && (clr_cnt == CLR_LAST)) state_nx = RUN;
      RUN:     if (clear_req) state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  // Reads win the port; in CLEAR an in-flight read stalls the wipe one cycle.
  // Clear writes are held off while reset is asserted so sram_we rests at 0.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we    = 1'b0;
    wb_pop     = 1'b0;
    clr_write  = 1'b0;
    busy       = (state == CLEAR);
    if (rd_slot) begin
      sram_addr = s1_addr;
    end else if (state == CLEAR) begin
      if (reset) begin
        clr_write = 1'b1;
        sram_we   = 1'b1;
        sram_addr = clr_cnt;
      end
    end else if (!clear_req && !wb_empty) begin
      wb_pop     = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = wb_head.addr;
      sram_wdata = wb_head.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          clr_cnt <= '0;
    else if ((state == RUN) && clear_req) clr_cnt <= '0;
    else if (clr_write)                  clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (wb_drop) overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_valid   <= 1'b0;
      Cb            <= '0;
      Cr            <= '0;
      read_x        <= '0;
      read_y        <= '0;
      read_addr     <= '0;
      color_history <= '0;
    end else begin
      color_valid <= tag_pop;
      if (tag_pop) begin
        Cb            <= tag_out.cb;
        Cr            <= tag_out.cr;
        read_x        <= tag_out.x;
        read_y        <= tag_out.y;
        read_addr     <= tag_out.addr;
        color_history <= tag_out.hit ? sram_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_history_mem_ctrl.sv
// Scoreboard bench for history_mem_ctrl on an 8x4 frame with a behavioural SRAM.
module tb_history_mem_ctrl;

  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned HW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic [9:0]    pix_x, pix_y;
  logic [7:0]    pix_Cb, pix_Cr;
  logic          clear_req;
  logic [7:0]    Cb, Cr;
  logic [9:0]    read_x, read_y;
  logic [AW-1:0] read_addr;
  logic [HW-1:0] color_history;
  logic          color_valid;
  logic          we;
  logic [AW-1:0] write_addr;
  logic [HW-1:0] updated_color_history;
  logic [AW-1:0] sram_addr;
  logic [HW-1:0] sram_wdata;
  logic          sram_we;
  logic [HW-1:0] sram_rdata;
  logic          busy;
  logic          overflow;

  history_mem_ctrl #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .ADDR_W   (AW),
    .HIST_W   (HW),
    .WB_DEPTH (4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .pix_valid             (pix_valid),
    .pix_x                 (pix_x),
    .pix_y                 (pix_y),
    .pix_Cb                (pix_Cb),
    .pix_Cr                (pix_Cr),
    .clear_req             (clear_req),
    .Cb                    (Cb),
    .Cr                    (Cr),
    .read_x                (read_x),
    .read_y                (read_y),
    .read_addr             (read_addr),
    .color_history         (color_history),
    .color_valid           (color_valid),
    .we                    (we),
    .write_addr            (write_addr),
    .updated_color_history (updated_color_history),
    .sram_addr             (sram_addr),
    .sram_wdata            (sram_wdata),
    .sram_we               (sram_we),
    .sram_rdata            (sram_rdata),
    .busy                  (busy),
    .overflow              (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with a side port for bench preloads.
  logic [HW-1:0] mem [32];
  logic          pl_en = 1'b0;
  logic          pl_all = 1'b0;
  logic [4:0]    pl_addr = '0;
  logic [HW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_all) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'hF;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (sram_we && (sram_addr < 19'd32)) begin
      mem[sram_addr[4:0]] <= sram_wdata;
    end
    sram_rdata <= (sram_addr < 19'd32) ? mem[sram_addr[4:0]] : 4'h0;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned addr;
    int unsigned hist;
    int unsigned cb;
    int unsigned cr;
    int unsigned x;
    int unsigned y;
    int unsigned cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (color_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_color_valid", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("latency", cyc - mon_e.cyc, 3);
        check("read_addr", read_addr, mon_e.addr);
        check("color_history", color_history, mon_e.hist);
        check("Cb", Cb, mon_e.cb);
        check("Cr", Cr, mon_e.cr);
        check("read_x", read_x, mon_e.x);
        check("read_y", read_y, mon_e.y);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_pix();
    pix_valid = 1'b0;
  endtask

  task automatic issue_pix(input int unsigned x, input int unsigned y, input int unsigned cb,
                           input int unsigned cr, input int unsigned ehist, input int unsigned eaddr);
    exp_t e;
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_Cb    = 8'(cb);
    pix_Cr    = 8'(cr);
    e.addr = eaddr; e.hist = ehist; e.cb = cb; e.cr = cr; e.x = x; e.y = y; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic preload(input int unsigned a, input int unsigned d);
    pl_addr = 5'(a);
    pl_data = 4'(d);
    pl_en   = 1'b1;
    tick(1);
    pl_en   = 1'b0;
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      tick(1);
    end
    check(nm, n, exp);
  endtask

  task automatic check_mem_zero(input string nm);
    int nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 4'h0) nz++;
    check(nm, nz, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_Cb = '0; pix_Cr = '0;
    clear_req = 1'b0; we = 1'b0; write_addr = '0; updated_color_history = '0;
    tick(2);

    check("rst_color_valid", color_valid, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_busy", busy, 1);
    check("rst_overflow", overflow, 0);
    check("rst_Cb", Cb, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_color_history", color_history, 0);

    pl_all = 1'b1;
    tick(1);
    pl_all = 1'b0;
    reset  = 1'b1;
    count_busy("init_clear_cycles", 32);
    check("busy_low_after_clear", busy, 0);
    check_mem_zero("init_clear_mem");

    preload(21, 4'hA);
    preload(17, 4'hC);
    preload(2, 4'h7);
    preload(31, 4'h9);

    issue_pix(5, 2, 8'h30, 8'h40, 4'hA, 21);
    tick(1); idle_pix(); tick(4);
    issue_pix(7, 3, 8'hE1, 8'hE2, 4'h9, 31);
    tick(1); idle_pix(); tick(4);

    we = 1'b1; write_addr = 19'd21; updated_color_history = 4'h5;
    check("wb_not_same_cycle", sram_we, 0);
    tick(1);
    we = 1'b0;
    check("wb_sram_we", sram_we, 1);
    check("wb_sram_addr", sram_addr, 21);
    check("wb_sram_wdata", sram_wdata, 5);
    tick(1);
    check("wb_mem21", mem[21], 4'h5);
    tick(2);
    issue_pix(5, 2, 8'h31, 8'h41, 4'h5, 21);
    tick(1); idle_pix(); tick(4);

    issue_pix(9, 1, 8'h55, 8'h66, 0, 0);
    tick(1); idle_pix();
    check("oor_x_no_read", (sram_addr == 19'd17) ? 1 : 0, 0);
    tick(4);
    issue_pix(3, 4, 8'h57, 8'h68, 0, 0);
    tick(1); idle_pix(); tick(4);

    // we every cycle for 8 cycles, pixel every 2: 4 + 3 drained accepted, 8th dropped.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; write_addr = 19'(8 + i); updated_color_history = 4'(i + 1);
      if (i % 2 == 0) issue_pix(i / 2, 0, 8'h10 + i, 8'h20 + i, (i / 2 == 2) ? 4'h7 : 4'h0, i / 2);
      else idle_pix();
      if (i == 7) check("ovf_before_drop", overflow, 0);
      tick(1);
    end
    we = 1'b0; idle_pix();
    check("ovf_after_drop", overflow, 1);
    tick(12);
    check("ovf_sticky", overflow, 1);
    for (int i = 0; i < 7; i++) check("ovf_accepted_write", mem[8 + i], i + 1);
    check("ovf_dropped_write", mem[15], 0);

    issue_pix(5, 2, 8'h77, 8'h88, 4'h5, 21);
    we = 1'b1; write_addr = 19'd10; updated_color_history = 4'h3;
    tick(1);
    idle_pix();
    write_addr = 19'd11; updated_color_history = 4'h4;
    tick(1);
    we = 1'b0; clear_req = 1'b1;
    check("clr_busy_before", busy, 0);
    tick(1);
    clear_req = 1'b0;
    check("clr_busy_entered", busy, 1);
    check("clr_ovf_kept", overflow, 1);
    count_busy("req_clear_cycles", 32);
    tick(5);
    check("clr_flushed_10", mem[10], 0);
    check("clr_flushed_11", mem[11], 0);
    check_mem_zero("req_clear_mem");

    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(10);
    reset = 1'b0;
    #1;
    check("midclr_busy", busy, 1);
    check("midclr_ovf_reset", overflow, 0);
    pl_all = 1'b1;
    tick(1);
    pl_all = 1'b0;
    tick(1);
    reset = 1'b1;
    count_busy("restart_clear_cycles", 32);
    check_mem_zero("restart_clear_mem");

    tick(5);
    check("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
